// File: rtl/draw_pkg.sv
// Shared drawing definitions: frame defaults, FSM state encoding and address-width helper.
package draw_pkg;
  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  function automatic int addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction
endpackage

// File: rtl/rect_drawer_if.sv
// Request side (from plot controller) plus frame-buffer write port of the rectangle drawer.
interface rect_drawer_if
  import draw_pkg::*;
#(
  parameter int COORD_WIDTH = 10,
  parameter int COLOR_WIDTH = 1,
  parameter int ADDR_WIDTH  = addr_width(FRAME_WIDTH, FRAME_HEIGHT)
);
  logic                   start;
  logic                   abort;
  logic [COORD_WIDTH-1:0] x0, y0, x1, y1;
  logic [COLOR_WIDTH-1:0] color;
  logic                   ready;
  logic                   done;
  logic                   write_enable;
  logic [ADDR_WIDTH-1:0]  write_addr;
  logic [COLOR_WIDTH-1:0] write_data;

  modport master (
    output start, abort, x0, y0, x1, y1, color,
    input  ready, done, write_enable, write_addr, write_data
  );

  modport slave (
    input  start, abort, x0, y0, x1, y1, color,
    output ready, done, write_enable, write_addr, write_data
  );
endinterface

// File: rtl/rect_clip.sv
// Combinational clip of the bottom-right corner to the frame, plus empty-rectangle detect.
module rect_clip
  import draw_pkg::*;
#(
  parameter int WIDTH       = FRAME_WIDTH,
  parameter int HEIGHT      = FRAME_HEIGHT,
  parameter int COORD_WIDTH = 10
) (
  input  logic [COORD_WIDTH-1:0] i_x0,
  input  logic [COORD_WIDTH-1:0] i_y0,
  input  logic [COORD_WIDTH-1:0] i_x1,
  input  logic [COORD_WIDTH-1:0] i_y1,
  output logic [COORD_WIDTH-1:0] o_x1c,
  output logic [COORD_WIDTH-1:0] o_y1c,
  output logic                   o_empty
);
  localparam logic [31:0] XMAX = 32'(WIDTH - 1);
  localparam logic [31:0] YMAX = 32'(HEIGHT - 1);

  // Compare in 32 bits so coordinates wider than the frame range clip correctly.
  logic [31:0] w_x0, w_y0, w_x1, w_y1;
  assign w_x0 = 32'(i_x0);
  assign w_y0 = 32'(i_y0);
  assign w_x1 = 32'(i_x1);
  assign w_y1 = 32'(i_y1);

  assign o_x1c = (w_x1 > XMAX) ? COORD_WIDTH'(XMAX) : i_x1;
  assign o_y1c = (w_y1 > YMAX) ? COORD_WIDTH'(YMAX) : i_y1;

  assign o_empty = (w_x0 > 32'(o_x1c)) || (w_y0 > 32'(o_y1c)) ||
                   (w_x0 > XMAX) || (w_y0 > YMAX);
endmodule

// File: rtl/rect_drawer.sv
// Fills an axis-aligned, clipped rectangle with one colour, one pixel per clock in raster order.
module rect_drawer
  import draw_pkg::*;
#(
  parameter int WIDTH       = FRAME_WIDTH,
  parameter int HEIGHT      = FRAME_HEIGHT,
  parameter int COLOR_WIDTH = 1,
  parameter int ADDR_WIDTH  = addr_width(WIDTH, HEIGHT),
  parameter int COORD_WIDTH = 10
) (
  input logic         clk,
  input logic         rst,
  rect_drawer_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(WIDTH);

  state_t                 r_state;
  logic                   r_ready, r_done, r_we;
  logic [ADDR_WIDTH-1:0]  r_addr, r_row_base;
  logic [COLOR_WIDTH-1:0] r_data;
  logic [COORD_WIDTH-1:0] r_x0, r_y0, r_x1, r_y1, r_x, r_y;

  logic [COORD_WIDTH-1:0] w_x1c, w_y1c;
  logic                   w_empty;
  logic [ADDR_WIDTH-1:0]  w_row0;

  rect_clip #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COORD_WIDTH(COORD_WIDTH)
  ) u_clip (
    .i_x0(r_x0), .i_y0(r_y0), .i_x1(r_x1), .i_y1(r_y1),
    .o_x1c(w_x1c), .o_y1c(w_y1c), .o_empty(w_empty)
  );

  // One constant multiply at setup; rows after that advance by adding WIDTH.
  assign w_row0 = ADDR_WIDTH'(32'(r_y0) * 32'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_row_base <= '0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_x0    <= bus.x0;
            r_y0    <= bus.y0;
            r_x1    <= bus.x1;
            r_y1    <= bus.y1;
            r_data  <= bus.color;
            r_ready <= 1'b0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (bus.abort || w_empty) begin
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_x1       <= w_x1c;
            r_y1       <= w_y1c;
            r_x        <= r_x0;
            r_y        <= r_y0;
            r_row_base <= w_row0;
            r_addr     <= w_row0 + ADDR_WIDTH'(r_x0);
            r_we       <= 1'b1;
            r_state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          // r_x/r_y name the pixel currently on the write port.
          if (bus.abort || (r_x == r_x1 && r_y == r_y1)) begin
            r_we    <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_x == r_x1) begin
            r_x        <= r_x0;
            r_y        <= r_y + 1'b1;
            r_row_base <= r_row_base + ROW_STEP;
            r_addr     <= r_row_base + ROW_STEP + ADDR_WIDTH'(r_x0);
          end else begin
            r_x    <= r_x + 1'b1;
            r_addr <= r_addr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready        = r_ready;
  assign bus.done         = r_done;
  assign bus.write_enable = r_we;
  assign bus.write_addr   = r_addr;
  assign bus.write_data   = r_data;
endmodule
